// File: rtl/rx_pkg.sv
// Shared types and constants for the receive byte assembler.
package rx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    ERR  = 2'd2
  } rx_state_t;

  localparam int STUFF_LEN_DEF = 6;

  // Counter width able to hold values 0..max_val.
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/flex_stp_sr.sv
// Serial-to-parallel shift register, resets to all ones; direction chosen by SHIFT_MSB.
module flex_stp_sr #(
  parameter int NUM_BITS  = 8,
  parameter bit SHIFT_MSB = 1'b0
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                shift_enable,
  input  logic                serial_in,
  output logic [NUM_BITS-1:0] parallel_out
);

  logic [NUM_BITS-1:0] shift_r;

  // Shift storage: MSB-first enters at bit 0, LSB-first enters at the top bit.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      shift_r <= '1;
    end else if (shift_enable) begin
      if (SHIFT_MSB) begin
        shift_r <= {shift_r[NUM_BITS-2:0], serial_in};
      end else begin
        shift_r <= {serial_in, shift_r[NUM_BITS-1:1]};
      end
    end else begin
      shift_r <= shift_r;
    end
  end

  assign parallel_out = shift_r;

endmodule

// File: rtl/rx_byte_assembler.sv
// NRZI decode, bit-unstuffing and word assembly for the receive path, with a
// one-entry valid/ack holding register and sticky overrun / pulsed error flags.
module rx_byte_assembler
  import rx_pkg::*;
#(
  parameter int NUM_BITS  = 8,
  parameter bit SHIFT_MSB = 1'b0,
  parameter int STUFF_LEN = STUFF_LEN_DEF
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                serial_in,
  input  logic                bit_strobe,
  input  logic                frame_active,
  input  logic                byte_ack,
  output logic [NUM_BITS-1:0] rx_data,
  output logic                rx_valid,
  output logic                overrun,
  output logic                stuff_err,
  output logic                align_err
);

  localparam int BW = cnt_width(NUM_BITS);
  localparam int OW = cnt_width(STUFF_LEN);

  rx_state_t           state_r, state_nxt_s;
  logic                prev_level_r, prev_level_nxt_s;
  logic [OW-1:0]       ones_cnt_r, ones_cnt_nxt_s;
  logic [BW-1:0]       bit_cnt_r, bit_cnt_nxt_s;
  logic [NUM_BITS-1:0] rx_data_r, rx_data_nxt_s;
  logic                rx_valid_r, rx_valid_nxt_s;
  logic                overrun_r, overrun_nxt_s;
  logic                stuff_err_r, stuff_err_nxt_s;
  logic                align_err_r, align_err_nxt_s;

  logic                dec_bit_s;
  logic                stuffed_s;
  logic                shift_en_s;
  logic                word_done_s;
  logic [NUM_BITS-1:0] sr_out_s;
  logic [NUM_BITS-1:0] word_s;

  flex_stp_sr #(
    .NUM_BITS  (NUM_BITS),
    .SHIFT_MSB (SHIFT_MSB)
  ) u_sr (
    .clk          (clk),
    .n_rst        (n_rst),
    .shift_enable (shift_en_s),
    .serial_in    (dec_bit_s),
    .parallel_out (sr_out_s)
  );

  assign dec_bit_s = (serial_in == prev_level_r);
  assign stuffed_s = (ones_cnt_r == OW'(STUFF_LEN));
  // The completing bit is not in the shift register yet, so build the word here.
  assign word_s    = SHIFT_MSB ? {sr_out_s[NUM_BITS-2:0], dec_bit_s}
                               : {dec_bit_s, sr_out_s[NUM_BITS-1:1]};

  // Next-state, decoder/counter and holding-register update logic.
  always_comb begin
    state_nxt_s      = state_r;
    prev_level_nxt_s = prev_level_r;
    ones_cnt_nxt_s   = ones_cnt_r;
    bit_cnt_nxt_s    = bit_cnt_r;
    rx_data_nxt_s    = rx_data_r;
    rx_valid_nxt_s   = rx_valid_r;
    overrun_nxt_s    = overrun_r;
    stuff_err_nxt_s  = 1'b0;
    align_err_nxt_s  = 1'b0;
    shift_en_s       = 1'b0;
    word_done_s      = 1'b0;

    case (state_r)
      IDLE: begin
        if (frame_active) begin
          state_nxt_s      = RECV;
          prev_level_nxt_s = 1'b1;
          ones_cnt_nxt_s   = '0;
          bit_cnt_nxt_s    = '0;
          overrun_nxt_s    = 1'b0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RECV: begin
        if (!frame_active) begin
          state_nxt_s     = IDLE;
          align_err_nxt_s = (bit_cnt_r != '0);
          bit_cnt_nxt_s   = '0;
        end else if (bit_strobe) begin
          prev_level_nxt_s = serial_in;
          if (stuffed_s) begin
            if (dec_bit_s) begin
              stuff_err_nxt_s = 1'b1;
              state_nxt_s     = ERR;
            end else begin
              ones_cnt_nxt_s = '0;
            end
          end else begin
            shift_en_s     = 1'b1;
            ones_cnt_nxt_s = dec_bit_s ? (ones_cnt_r + OW'(1)) : '0;
            if (bit_cnt_r == BW'(NUM_BITS - 1)) begin
              bit_cnt_nxt_s = '0;
              word_done_s   = 1'b1;
            end else begin
              bit_cnt_nxt_s = bit_cnt_r + BW'(1);
            end
          end
        end else begin
          state_nxt_s = RECV;
        end
      end
      ERR: begin
        if (!frame_active) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = ERR;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase

    // A same-cycle ack frees the holding register for the completing word.
    if (word_done_s) begin
      if (!rx_valid_r || byte_ack) begin
        rx_data_nxt_s  = word_s;
        rx_valid_nxt_s = 1'b1;
      end else begin
        overrun_nxt_s = 1'b1;
      end
    end else if (byte_ack) begin
      rx_valid_nxt_s = 1'b0;
    end else begin
      rx_valid_nxt_s = rx_valid_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      prev_level_r <= 1'b1;
      ones_cnt_r   <= '0;
      bit_cnt_r    <= '0;
      rx_data_r    <= '1;
      rx_valid_r   <= 1'b0;
      overrun_r    <= 1'b0;
      stuff_err_r  <= 1'b0;
      align_err_r  <= 1'b0;
    end else begin
      prev_level_r <= prev_level_nxt_s;
      ones_cnt_r   <= ones_cnt_nxt_s;
      bit_cnt_r    <= bit_cnt_nxt_s;
      rx_data_r    <= rx_data_nxt_s;
      rx_valid_r   <= rx_valid_nxt_s;
      overrun_r    <= overrun_nxt_s;
      stuff_err_r  <= stuff_err_nxt_s;
      align_err_r  <= align_err_nxt_s;
    end
  end

  assign rx_data   = rx_data_r;
  assign rx_valid  = rx_valid_r;
  assign overrun   = overrun_r;
  assign stuff_err = stuff_err_r;
  assign align_err = align_err_r;

endmodule

// File: tb/tb_rx_byte_assembler.sv
// Directed bench for rx_byte_assembler: NRZI stimulus, scoreboard popped on each consumer ack.
module tb_rx_byte_assembler;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       serial_in;
  logic       bit_strobe;
  logic       frame_active;
  logic       byte_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       overrun;
  logic       stuff_err;
  logic       align_err;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         stuff_seen = 0;
  int         align_seen = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  logic       level;

  always #5 clk = ~clk;

  rx_byte_assembler #(
    .NUM_BITS  (8),
    .SHIFT_MSB (1'b0),
    .STUFF_LEN (6)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .serial_in    (serial_in),
    .bit_strobe   (bit_strobe),
    .frame_active (frame_active),
    .byte_ack     (byte_ack),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .overrun      (overrun),
    .stuff_err    (stuff_err),
    .align_err    (align_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Send one decoded bit as an NRZI line level (0 = transition, 1 = hold).
  task automatic strobe(input logic b, input logic ack);
    if (!b) level = ~level;
    serial_in  = level;
    bit_strobe = 1'b1;
    byte_ack   = ack;
    tick();
    bit_strobe = 1'b0;
    byte_ack   = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input logic ack_last);
    for (int i = 0; i < 8; i++) strobe(w[i], (i == 7) ? ack_last : 1'b0);
  endtask

  task automatic start_frame;
    level        = 1'b1;
    frame_active = 1'b1;
    tick();
  endtask

  task automatic end_frame;
    frame_active = 1'b0;
    tick();
  endtask

  task automatic ack_word;
    byte_ack = 1'b1;
    tick();
    byte_ack = 1'b0;
  endtask

  initial begin
    n_rst        = 1'b0;
    serial_in    = 1'b1;
    bit_strobe   = 1'b0;
    frame_active = 1'b0;
    byte_ack     = 1'b0;
    level        = 1'b1;

    fork
      forever begin
        @(negedge clk);
        if (n_rst) begin
          if (stuff_err) stuff_seen++;
          if (align_err) align_seen++;
          if (rx_valid && byte_ack) begin
            if (exp_q.size() == 0) begin
              n_tests++;
              n_fail++;
              $display("FAIL sb_unexpected_word: got %0h expected none", rx_data);
            end else begin
              mon_exp = exp_q.pop_front();
              check("sb_word", rx_data, mon_exp);
            end
          end
        end
      end
    join_none

    tick();
    tick();
    check("rst_rx_data", rx_data, 8'hFF);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_stuff_err", stuff_err, 1'b0);
    check("rst_align_err", align_err, 1'b0);
    n_rst = 1'b1;
    tick();

    // 1: single word A5, no ack
    start_frame();
    for (int i = 0; i < 8; i++) begin
      strobe(((8'hA5 >> i) & 8'h01) != 8'h00, 1'b0);
      if (i == 6) check("t1_valid_before_8th", rx_valid, 1'b0);
    end
    check("t1_valid", rx_valid, 1'b1);
    check("t1_data", rx_data, 8'hA5);
    check("t1_stuff_err", stuff_err, 1'b0);
    exp_q.push_back(8'hA5);
    end_frame();
    check("t1_align_err", align_err, 1'b0);
    ack_word();
    check("t1_valid_after_ack", rx_valid, 1'b0);

    // 2: FF with stuffed 0 after six 1s, then 00
    start_frame();
    for (int i = 0; i < 6; i++) strobe(1'b1, 1'b0);
    strobe(1'b0, 1'b0);
    strobe(1'b1, 1'b0);
    strobe(1'b1, 1'b0);
    check("t2_valid_ff", rx_valid, 1'b1);
    check("t2_data_ff", rx_data, 8'hFF);
    exp_q.push_back(8'hFF);
    ack_word();
    send_word(8'h00, 1'b0);
    check("t2_data_00", rx_data, 8'h00);
    check("t2_stuff_err", stuff_err, 1'b0);
    exp_q.push_back(8'h00);
    ack_word();
    end_frame();
    check("t2_align_err", align_err, 1'b0);

    // 3: seven consecutive 1s -> stuff error, then ERR ignores strobes
    start_frame();
    for (int i = 0; i < 7; i++) strobe(1'b1, 1'b0);
    check("t3_stuff_pulse", stuff_err, 1'b1);
    tick();
    check("t3_stuff_single", stuff_err, 1'b0);
    send_word(8'h00, 1'b0);
    check("t3_no_word_in_err", rx_valid, 1'b0);
    end_frame();
    check("t3_no_align_from_err", align_err, 1'b0);

    // 4a: two words, no ack -> overrun, first word kept
    start_frame();
    send_word(8'h12, 1'b0);
    send_word(8'h34, 1'b0);
    check("t4a_data", rx_data, 8'h12);
    check("t4a_overrun", overrun, 1'b1);
    exp_q.push_back(8'h12);
    end_frame();
    check("t4a_overrun_sticky", overrun, 1'b1);
    ack_word();
    // 4b: ack coincides with second completion
    start_frame();
    check("t4b_overrun_cleared", overrun, 1'b0);
    send_word(8'h12, 1'b0);
    exp_q.push_back(8'h12);
    send_word(8'h34, 1'b1);
    check("t4b_data", rx_data, 8'h34);
    check("t4b_valid", rx_valid, 1'b1);
    check("t4b_overrun", overrun, 1'b0);
    exp_q.push_back(8'h34);
    end_frame();
    ack_word();

    // 5: partial frame of 5 bits -> align_err, then 3C assembles cleanly
    start_frame();
    strobe(1'b1, 1'b0);
    strobe(1'b0, 1'b0);
    strobe(1'b1, 1'b0);
    strobe(1'b0, 1'b0);
    strobe(1'b1, 1'b0);
    end_frame();
    check("t5_align_pulse", align_err, 1'b1);
    tick();
    check("t5_align_single", align_err, 1'b0);
    start_frame();
    send_word(8'h3C, 1'b0);
    check("t5_data", rx_data, 8'h3C);
    exp_q.push_back(8'h3C);
    end_frame();
    check("t5_align_clean", align_err, 1'b0);
    ack_word();

    // 6: async reset mid-word, then C3 decodes
    start_frame();
    send_word(8'h5A, 1'b0);
    check("t6_valid_before_rst", rx_valid, 1'b1);
    for (int i = 0; i < 4; i++) strobe(i[0], 1'b0);
    n_rst = 1'b0;
    #1;
    check("t6_rst_data", rx_data, 8'hFF);
    check("t6_rst_valid", rx_valid, 1'b0);
    check("t6_rst_overrun", overrun, 1'b0);
    check("t6_rst_errs", {stuff_err, align_err}, 2'b00);
    frame_active = 1'b0;
    tick();
    tick();
    n_rst = 1'b1;
    tick();
    start_frame();
    send_word(8'hC3, 1'b0);
    check("t6_data", rx_data, 8'hC3);
    check("t6_valid", rx_valid, 1'b1);
    exp_q.push_back(8'hC3);
    end_frame();
    ack_word();
    tick();

    check("end_stuff_pulses", stuff_seen, 1);
    check("end_align_pulses", align_seen, 1);
    check("end_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
